noc_flit_tx_port: RTL and testbench

//  Upstream transmitter of a router link: drives data/valid_flit into a downstream router input

---
 rtl/noc_flit_tx_if.sv | 30 +++
 rtl/noc_flit_tx_port.sv | 145 ++++++++++++++
 tb/tb_noc_flit_tx_port.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_flit_tx_if.sv
// Link bundle between a flit source, the transmit port and the downstream router input.
// The transmit port takes the slave modport; the driving side takes the master modport.
interface noc_flit_tx_if #(
    parameter int VC_NUM    = 2,
    parameter int VC_W      = 1,
    parameter int PAYLOAD_W = 32,
    parameter int FLIT_W    = 2 + VC_W + PAYLOAD_W
);
    logic              enq_valid_i;
    logic [FLIT_W-1:0] enq_flit_i;
    logic              enq_ready_o;
    logic [FLIT_W-1:0] data_o;
    logic              valid_flit_o;
    logic [VC_NUM-1:0] on_off_i;
    logic [VC_NUM-1:0] vc_allocatable_i;
    logic [VC_NUM-1:0] error_i;
    logic [VC_NUM-1:0] err_seen_o;
    logic              proto_err_o;
    logic [15:0]       flit_cnt_o;

    modport slave (
        input  enq_valid_i, enq_flit_i, on_off_i, vc_allocatable_i, error_i,
        output enq_ready_o, data_o, valid_flit_o, err_seen_o, proto_err_o, flit_cnt_o
    );

    modport master (
        output enq_valid_i, enq_flit_i, on_off_i, vc_allocatable_i, error_i,
        input  enq_ready_o, data_o, valid_flit_o, err_seen_o, proto_err_o, flit_cnt_o
    );
endinterface

// File: rtl/noc_flit_tx_port.sv
// Router link transmitter: per-VC flit FIFOs with packet-sequence checking at enqueue,
// round-robin arbitration gated by downstream on_off / vc_allocatable, one flit per cycle.
module noc_flit_tx_port #(
    parameter int VC_NUM    = 2,
    parameter int VC_W      = 1,
    parameter int PAYLOAD_W = 32,
    parameter int BUF_DEPTH = 4,
    parameter int FLIT_W    = 2 + VC_W + PAYLOAD_W
) (
    input logic          clk,
    input logic          rst,
    noc_flit_tx_if.slave bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        FT_HEAD     = 2'b00,
        FT_BODY     = 2'b01,
        FT_TAIL     = 2'b10,
        FT_HEADTAIL = 2'b11
    } flit_type_e;

    logic [FLIT_W-1:0] r_mem [VC_NUM][BUF_DEPTH];
    logic [PW-1:0]     r_wptr [VC_NUM];
    logic [PW-1:0]     r_rptr [VC_NUM];
    logic [VC_NUM-1:0] r_enq_open;
    logic [VC_NUM-1:0] r_tx_active;
    logic [VC_W-1:0]   r_rr;
    logic [FLIT_W-1:0] r_data;
    logic              r_valid;
    logic [15:0]       r_flit_cnt;
    logic [VC_NUM-1:0] r_err_seen;
    logic              r_proto_err;

    logic [VC_NUM-1:0] w_empty;
    logic [VC_NUM-1:0] w_full;
    logic [VC_NUM-1:0] w_elig;
    logic [FLIT_W-1:0] w_head_flit [VC_NUM];
    logic              w_gnt;
    logic [VC_W-1:0]   w_gnt_vc;
    flit_type_e        w_gnt_type;
    flit_type_e        w_enq_type;
    logic [VC_W-1:0]   w_enq_vc;
    logic              w_enq_fire;
    logic              w_enq_legal;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_empty = '0;
        w_full  = '0;
        w_elig  = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            w_empty[v]     = (r_wptr[v] == r_rptr[v]);
            w_full[v]      = (r_wptr[v][AW] != r_rptr[v][AW]) &&
                             (r_wptr[v][AW-1:0] == r_rptr[v][AW-1:0]);
            w_head_flit[v] = r_mem[v][r_rptr[v][AW-1:0]];
            w_elig[v]      = !w_empty[v] && bus.on_off_i[v] &&
                             (r_tx_active[v] || bus.vc_allocatable_i[v]);
        end
    end

    // Round-robin: first eligible VC at or after the pointer wins.
    always_comb begin
        logic [VC_W-1:0] idx;
        idx      = '0;
        w_gnt    = 1'b0;
        w_gnt_vc = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = VC_W'((int'(r_rr) + i) % VC_NUM);
            if (!w_gnt && w_elig[idx]) begin
                w_gnt    = 1'b1;
                w_gnt_vc = idx;
            end
        end
        w_gnt_type = flit_type_e'(w_head_flit[w_gnt_vc][FLIT_W-1 -: 2]);
    end

    assign w_enq_type      = flit_type_e'(bus.enq_flit_i[FLIT_W-1 -: 2]);
    assign w_enq_vc        = bus.enq_flit_i[FLIT_W-3 -: VC_W];
    assign bus.enq_ready_o = !w_full[w_enq_vc];
    assign w_enq_fire      = bus.enq_valid_i && bus.enq_ready_o;
    assign w_enq_legal     = (w_enq_type == FT_HEAD || w_enq_type == FT_HEADTAIL) ?
                             !r_enq_open[w_enq_vc] : r_enq_open[w_enq_vc];

    // NOTE: flit storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_enq_fire && w_enq_legal)
            r_mem[w_enq_vc][r_wptr[w_enq_vc][AW-1:0]] <= bus.enq_flit_i;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VC_NUM; v++) begin
                r_wptr[v] <= '0;
                r_rptr[v] <= '0;
            end
            r_enq_open  <= '0;
            r_tx_active <= '0;
            r_rr        <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_flit_cnt  <= '0;
            r_err_seen  <= '0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_enq_fire) begin
                if (w_enq_legal) begin
                    r_wptr[w_enq_vc] <= r_wptr[w_enq_vc] + PW'(1);
                    case (w_enq_type)
                        FT_HEAD: r_enq_open[w_enq_vc] <= 1'b1;
                        FT_TAIL: r_enq_open[w_enq_vc] <= 1'b0;
                        default: ;
                    endcase
                end else begin
                    r_proto_err <= 1'b1;
                end
            end

            r_valid <= w_gnt;
            if (w_gnt) begin
                r_rptr[w_gnt_vc] <= r_rptr[w_gnt_vc] + PW'(1);
                r_data     <= {w_head_flit[w_gnt_vc][FLIT_W-1 -: 2], w_gnt_vc,
                               w_head_flit[w_gnt_vc][PAYLOAD_W-1:0]};
                r_flit_cnt <= r_flit_cnt + 16'd1;
                r_rr       <= VC_W'((int'(w_gnt_vc) + 1) % VC_NUM);
                case (w_gnt_type)
                    FT_HEAD: r_tx_active[w_gnt_vc] <= 1'b1;
                    FT_TAIL: r_tx_active[w_gnt_vc] <= 1'b0;
                    default: ;
                endcase
            end

            r_err_seen <= r_err_seen | bus.error_i;
        end
    end

    assign bus.data_o       = r_data;
    assign bus.valid_flit_o = r_valid;
    assign bus.flit_cnt_o   = r_flit_cnt;
    assign bus.err_seen_o   = r_err_seen;
    assign bus.proto_err_o  = r_proto_err;
endmodule

// File: tb/tb_noc_flit_tx_port.sv
// Directed stimulus for noc_flit_tx_port; expected flits are queued as stimulus is issued
// and a negedge monitor pops and compares each flit the port presents.
module tb_noc_flit_tx_port;
    localparam int VC_NUM    = 2;
    localparam int VC_W      = 1;
    localparam int PAYLOAD_W = 32;
    localparam int BUF_DEPTH = 4;
    localparam int FLIT_W    = 2 + VC_W + PAYLOAD_W;

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_BODY = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    noc_flit_tx_if #(.VC_NUM(VC_NUM), .VC_W(VC_W), .PAYLOAD_W(PAYLOAD_W), .FLIT_W(FLIT_W)) bus ();

    noc_flit_tx_port #(
        .VC_NUM(VC_NUM), .VC_W(VC_W), .PAYLOAD_W(PAYLOAD_W),
        .BUF_DEPTH(BUF_DEPTH), .FLIT_W(FLIT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int                checks   = 0;
    int                failures = 0;
    logic [FLIT_W-1:0] exp_q [$];
    logic [15:0]       exp_cnt  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [VC_W-1:0] vc,
                                             input logic [PAYLOAD_W-1:0] p);
        return {t, vc, p};
    endfunction

    // Scoreboard monitor: every presented flit must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && bus.valid_flit_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_flit: got %0h expected no flit", bus.data_o);
            end else begin
                check("flit_data", 64'(bus.data_o), 64'(exp_q.pop_front()));
                exp_cnt = exp_cnt + 16'd1;
                check("flit_cnt", 64'(bus.flit_cnt_o), 64'(exp_cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_cnt = '0;
        exp_q.delete();
    endtask

    task automatic enq(input logic [FLIT_W-1:0] flit, input logic exp_ready);
        bus.enq_valid_i = 1'b1;
        bus.enq_flit_i  = flit;
        #1;
        check("enq_ready", 64'(bus.enq_ready_o), 64'(exp_ready));
        tick();
        bus.enq_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    initial begin
        bus.enq_valid_i      = 1'b0;
        bus.enq_flit_i       = '0;
        bus.on_off_i         = 2'b11;
        bus.vc_allocatable_i = 2'b11;
        bus.error_i          = 2'b00;

        // Reset state
        do_reset();
        check("rst_valid",     64'(bus.valid_flit_o), 64'd0);
        check("rst_data",      64'(bus.data_o),       64'd0);
        check("rst_cnt",       64'(bus.flit_cnt_o),   64'd0);
        check("rst_ready",     64'(bus.enq_ready_o),  64'd1);
        check("rst_err_seen",  64'(bus.err_seen_o),   64'd0);
        check("rst_proto_err", 64'(bus.proto_err_o),  64'd0);

        // VC0 HEAD/BODY/TAIL back to back, one cycle of latency
        exp_q.push_back(mk(T_HEAD, 1'b0, 32'h0000_0A01));
        exp_q.push_back(mk(T_BODY, 1'b0, 32'h0000_0A02));
        exp_q.push_back(mk(T_TAIL, 1'b0, 32'h0000_0A03));
        enq(mk(T_HEAD, 1'b0, 32'h0000_0A01), 1'b1);
        check("lat_not_yet", 64'(bus.valid_flit_o), 64'd0);
        enq(mk(T_BODY, 1'b0, 32'h0000_0A02), 1'b1);
        check("lat_first_out", 64'(bus.valid_flit_o), 64'd1);
        enq(mk(T_TAIL, 1'b0, 32'h0000_0A03), 1'b1);
        wait_drain(10);
        check("cnt_after_pkt", 64'(bus.flit_cnt_o), 64'd3);

        // Two VCs with two flits each interleave round-robin from pointer 0
        do_reset();
        bus.on_off_i = 2'b00;
        enq(mk(T_HEAD, 1'b0, 32'h0000_B001), 1'b1);
        enq(mk(T_TAIL, 1'b0, 32'h0000_B002), 1'b1);
        enq(mk(T_HEAD, 1'b1, 32'h0000_B101), 1'b1);
        enq(mk(T_TAIL, 1'b1, 32'h0000_B102), 1'b1);
        exp_q.push_back(mk(T_HEAD, 1'b0, 32'h0000_B001));
        exp_q.push_back(mk(T_HEAD, 1'b1, 32'h0000_B101));
        exp_q.push_back(mk(T_TAIL, 1'b0, 32'h0000_B002));
        exp_q.push_back(mk(T_TAIL, 1'b1, 32'h0000_B102));
        bus.on_off_i = 2'b11;
        wait_drain(12);

        // vc_allocatable gates only the head; on_off stalls mid-packet
        bus.vc_allocatable_i = 2'b01;
        enq(mk(T_HEAD, 1'b1, 32'h0000_C101), 1'b1);
        repeat (5) tick();
        exp_q.push_back(mk(T_HEAD, 1'b1, 32'h0000_C101));
        bus.vc_allocatable_i = 2'b11;
        #1;
        check("alloc_hold_valid", 64'(bus.valid_flit_o), 64'd0);
        tick();
        check("alloc_release_valid", 64'(bus.valid_flit_o), 64'd1);
        bus.vc_allocatable_i = 2'b01;
        exp_q.push_back(mk(T_BODY, 1'b1, 32'h0000_C102));
        enq(mk(T_BODY, 1'b1, 32'h0000_C102), 1'b1);
        wait_drain(10);
        bus.on_off_i = 2'b01;
        enq(mk(T_TAIL, 1'b1, 32'h0000_C103), 1'b1);
        repeat (5) tick();
        exp_q.push_back(mk(T_TAIL, 1'b1, 32'h0000_C103));
        bus.on_off_i         = 2'b11;
        bus.vc_allocatable_i = 2'b11;
        wait_drain(10);

        // Fill VC0 while stalled; VC1 still accepts; ready returns after the first pop
        bus.on_off_i = 2'b10;
        enq(mk(T_HEAD, 1'b0, 32'h0000_D001), 1'b1);
        enq(mk(T_BODY, 1'b0, 32'h0000_D002), 1'b1);
        enq(mk(T_BODY, 1'b0, 32'h0000_D003), 1'b1);
        enq(mk(T_TAIL, 1'b0, 32'h0000_D004), 1'b1);
        enq(mk(T_HEAD, 1'b0, 32'h0000_DEAD), 1'b0);
        exp_q.push_back(mk(T_HT, 1'b1, 32'h0000_D1D1));
        enq(mk(T_HT, 1'b1, 32'h0000_D1D1), 1'b1);
        wait_drain(10);
        bus.enq_flit_i = mk(T_HEAD, 1'b0, 32'h0);
        exp_q.push_back(mk(T_HEAD, 1'b0, 32'h0000_D001));
        exp_q.push_back(mk(T_BODY, 1'b0, 32'h0000_D002));
        exp_q.push_back(mk(T_BODY, 1'b0, 32'h0000_D003));
        exp_q.push_back(mk(T_TAIL, 1'b0, 32'h0000_D004));
        bus.on_off_i = 2'b11;
        #1;
        check("full_ready_before_pop", 64'(bus.enq_ready_o), 64'd0);
        tick();
        check("full_ready_after_pop", 64'(bus.enq_ready_o), 64'd1);
        wait_drain(12);

        // Illegal BODY on idle VC is dropped; error_i pulse is held
        check("proto_err_clear", 64'(bus.proto_err_o), 64'd0);
        enq(mk(T_BODY, 1'b0, 32'h0000_E0E0), 1'b1);
        repeat (3) tick();
        check("proto_err_set", 64'(bus.proto_err_o), 64'd1);
        check("err_seen_clear", 64'(bus.err_seen_o), 64'd0);
        bus.error_i = 2'b10;
        tick();
        bus.error_i = 2'b00;
        repeat (2) tick();
        check("err_seen_held", 64'(bus.err_seen_o), 64'd2);
        exp_q.push_back(mk(T_HT, 1'b0, 32'h0000_E0F0));
        enq(mk(T_HT, 1'b0, 32'h0000_E0F0), 1'b1);
        wait_drain(10);
        check("final_cnt", 64'(bus.flit_cnt_o), 64'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
